// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  // Controller states of the divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default operand width (divisor, quotient, remainder).
  localparam int DIV_W = 8;

  // Bits needed for an iteration counter that must hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor and restore when the result would be negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] t_s;
  logic [WIDTH:0] dext_s;

  // Trial subtraction; a set top bit of rem means t exceeds any divisor.
  always_comb begin
    t_s    = {rem_i[WIDTH-1:0], bit_i};
    dext_s = {1'b0, dvsr_i};
    if (rem_i[WIDTH] || (t_s >= dext_s)) begin
      qbit_o = 1'b1;
      rem_o  = t_s - dext_s;
    end else begin
      qbit_o = 1'b0;
      rem_o  = t_s;
    end
  end

endmodule

// File: rtl/eight_bit_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock. The low dividend half and the quotient share
// one shift register: dividend bits leave at the MSB while quotient bits
// enter at the LSB.
// Optional macro EIGHT_BIT_DIVIDER_ERR_EN: flags divide-by-zero and quotient
// overflow at acceptance and reports err with all-ones q/r instead of running.
module eight_bit_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2*WIDTH-1:0] x,
  input  logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;   // invalid operands latched, report next edge

  logic             accept_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (shf_q[WIDTH-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Next-state, datapath load/iterate and output-register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvsr_d   = dvsr_q;
    shf_d    = shf_q;
    rem_d    = rem_q;
    q_d      = q_q;
    r_d      = r_q;
    err_d    = err_q;
    pend_d   = pend_q;
    accept_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = DONE;
          q_d     = {WIDTH{1'b1}};
          r_d     = {WIDTH{1'b1}};
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end else if (en) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_rem_s;
        shf_d = {shf_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          q_d     = {shf_q[WIDTH-2:0], step_qbit_s};
          r_d     = step_rem_s[WIDTH-1:0];
          err_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (en) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s) begin
      dvsr_d = y;
      shf_d  = x[WIDTH-1:0];
      rem_d  = {1'b0, x[2*WIDTH-1:WIDTH]};
      cnt_d  = CW'(WIDTH);
`ifdef EIGHT_BIT_DIVIDER_ERR_EN
      if ((y == {WIDTH{1'b0}}) || (x[2*WIDTH-1:WIDTH] >= y)) begin
        state_d = IDLE;
        pend_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
`else
      state_d = RUN;
`endif
    end else begin
      pend_d = pend_d;
    end

`ifndef EIGHT_BIT_DIVIDER_ERR_EN
    err_d  = 1'b0;
    pend_d = 1'b0;
`endif

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      dvsr_q  <= {WIDTH{1'b0}};
      shf_q   <= {WIDTH{1'b0}};
      rem_q   <= {(WIDTH+1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      shf_q   <= shf_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_eight_bit_divider.sv
// Self-checking bench for eight_bit_divider: directed cases, randomized valid
// operands against integer / and %, mid-run reset, back-to-back operation and,
// when EIGHT_BIT_DIVIDER_ERR_EN is defined, the error path.
module tb_eight_bit_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] x;
  logic [7:0]  y;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  eight_bit_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division of the dividend by the divisor.
  function automatic logic [7:0] ref_q(input logic [15:0] xv, input logic [7:0] yv);
    int unsigned quo;
    quo = int'(xv) / int'(yv);
    return quo[7:0];
  endfunction

  function automatic logic [7:0] ref_r(input logic [15:0] xv, input logic [7:0] yv);
    int unsigned rm;
    rm = int'(xv) % int'(yv);
    return rm[7:0];
  endfunction

  // Accept one valid operation, scramble inputs during RUN, check timing and result.
  task automatic run_op(input logic [15:0] xv, input logic [7:0] yv, input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    int early;
    eq = ref_q(xv, yv);
    er = ref_r(xv, yv);
    @(negedge clk);
    en = 1'b1; x = xv; y = yv;
    @(negedge clk);
    en = 1'b0;
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) early++;
      x = 16'($urandom); y = 8'($urandom);
    end
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL %s busy/done during run: %0d bad cycles, required 0", tag, early);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done timing: done=%b busy=%b, required done=1 busy=0", tag, done, busy);
    end
    n_tests++;
    if (q !== eq || r !== er || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: q=%0d r=%0d err=%b, required q=%0d r=%0d err=0",
               tag, q, r, err, eq, er);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || q !== eq || r !== er) begin
      n_fail++;
      $display("FAIL %s hold: done=%b q=%0d r=%0d, required done=0 q=%0d r=%0d",
               tag, done, q, r, eq, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; x = 16'd72; y = 8'd9;
    repeat (3) @(negedge clk);
    n_tests++;
    if (q !== 8'd0 || r !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: q=%0d r=%0d busy=%b done=%b err=%b, required all 0",
               q, r, busy, done, err);
    end
    en = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(16'd72, 8'd9, "div_72_9");
    run_op(16'd1000, 8'd7, "div_1000_7");
    run_op(16'hFEFF, 8'hFF, "div_feff_ff");
    run_op(16'h00FF, 8'd1, "div_by_one");
  endtask

  task automatic test_random();
    logic [7:0] yv;
    logic [7:0] hi;
    for (int i = 0; i < 20; i++) begin
      yv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(yv) - 1));
      run_op({hi, 8'($urandom)}, yv, "random");
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    en = 1'b1; x = 16'd1000; y = 8'd7;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (q !== 8'd0 || r !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: q=%0d r=%0d busy=%b done=%b err=%b, required all 0",
               q, r, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", seen);
    end
    run_op(16'd72, 8'd9, "after_abort");
  endtask

  task automatic test_back_to_back();
    int bad;
    @(negedge clk);
    en = 1'b1; x = 16'd1000; y = 8'd7;
    @(negedge clk);
    x = 16'd72; y = 8'd9;
    bad = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 8) begin
        n_tests++;
        if (done !== 1'b1 || q !== 8'd142 || r !== 8'd6) begin
          n_fail++;
          $display("FAIL b2b_first: done=%b q=%0d r=%0d, required done=1 q=142 r=6", done, q, r);
        end
      end else if (k == 17) begin
        n_tests++;
        if (done !== 1'b1 || q !== 8'd8 || r !== 8'd0) begin
          n_fail++;
          $display("FAIL b2b_second: done=%b q=%0d r=%0d, required done=1 q=8 r=0", done, q, r);
        end
      end else if (done !== 1'b0) begin
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d stray done cycles, required 0", bad);
    end
    en = 1'b0;
    repeat (12) @(negedge clk);
  endtask

`ifdef EIGHT_BIT_DIVIDER_ERR_EN
  task automatic run_err(input logic [15:0] xv, input logic [7:0] yv, input string tag);
    @(negedge clk);
    en = 1'b1; x = xv; y = yv;
    @(negedge clk);
    en = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s err_pre: done=%b busy=%b, required 0 0", tag, done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || q !== 8'hFF || r !== 8'hFF) begin
      n_fail++;
      $display("FAIL %s err_report: done=%b err=%b busy=%b q=%h r=%h, required 1 1 0 ff ff",
               tag, done, err, busy, q, r);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL %s err_hold: done=%b err=%b, required done=0 err=1", tag, done, err);
    end
  endtask

  task automatic test_err();
    run_err(16'd1000, 8'd0, "div_by_zero");
    run_err(16'h0900, 8'd9, "overflow");
    run_op(16'd1000, 8'd7, "valid_after_err");
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b0; x = 16'd0; y = 8'd0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
`ifdef EIGHT_BIT_DIVIDER_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eight_bit_divider.md
# eight_bit_divider

Sequential restoring divider, the inverse of `eight_bit_multiplier`: divides a 16-bit dividend by an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. It uses the same `clk`/`reset`/`en` control style as the multiplier and produces one quotient bit per clock. A product from the multiplier can be fed back here, for example to check results in the arithmetic lab datapath.

## Interface
- `WIDTH`, default 8: divisor, quotient and remainder width; the dividend is 2*WIDTH.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; sampled only when the FSM is in IDLE or DONE.
- `x`  in  2*WIDTH  dividend; sampled at the accepting edge.
- `y`  in  WIDTH  divisor; sampled at the accepting edge.
- `q`  out  WIDTH  quotient; registered; holds until the next result.
- `r`  out  WIDTH  remainder; registered; holds until the next result.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `q`/`r`/`err` are valid from this cycle on.
- `err`  out  1  divide-by-zero or quotient overflow. Present only with the macro; otherwise tied 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `en`=1 → accept, go to RUN.
  - RUN: stays for WIDTH iterations, then → DONE.
  - DONE: lasts one cycle. `en`=1 → accept, go to RUN; else → IDLE.
- Accept action: latch `y` into the divisor register and `x[WIDTH-1:0]` into the shift register. Load the partial remainder `rem` (WIDTH+1 bits) with `{1'b0, x[2W-1:W]}`. Load the iteration counter with WIDTH.
- Each RUN iteration:
  - t = `{rem[W-1:0], next dividend bit MSB-first}`.
  - If t ≥ divisor: `rem` = t − divisor, quotient bit = 1.
  - Otherwise: `rem` = t, quotient bit = 0.
  - Quotient bits shift in LSB-wards.
  - t < 2·divisor always holds, so WIDTH+1 bits are sufficient.
- Precondition for a valid result: divisor ≠ 0 and `x[2W-1:W]` < `y`, so the quotient fits in WIDTH bits.
- On entering DONE: `q` ← quotient register, `r` ← `rem[W-1:0]`, `done` = 1.
- `en` during RUN is ignored and does not restart the operation. `x`/`y` changes after acceptance have no effect.
- `en` held high keeps the divider running operations back to back.

## Timing
- Reset values: `q`=0, `r`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counter 0.
- Acceptance at edge N. Iterations run at edges N+1..N+8 (WIDTH=8). `busy` is high after edge N through edge N+8.
- State is DONE after edge N+8. `done`=1 and the new `q`/`r` are visible from edge N+8 to edge N+9.
- Latency is WIDTH cycles from acceptance to `done`. With `en` held high, throughput is one result every WIDTH+1 cycles.
- Reset asserted mid-RUN aborts immediately: all outputs return to reset values and no `done` is produced for the aborted operation.
- Reset and `en` asserted together: reset wins.

## Configuration
- Macro `EIGHT_BIT_DIVIDER_ERR_EN`.
- Defined: at acceptance, if `y`==0 or `x[2W-1:W]` ≥ `y`, the FSM skips RUN and goes directly to DONE. At edge N+1: `err`=1, `q`=all-ones, `r`=all-ones, `done`=1, and `busy` never rises. For a valid operation, `err`=0 at `done`. `err` holds with `q`/`r`.
- Undefined: no check is made. Invalid operands run the full WIDTH iterations, `q`/`r` are unspecified, and the `err` port is tied 0.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, RUN, DONE}
  - localparam `DIV_W` = 8
  - counter-width function (`$clog2(WIDTH+1)`)
- Sub-module `div_step`: combinational single iteration. Inputs are `rem`, the dividend bit and the divisor. Outputs are the next `rem` and the quotient bit. The top level holds the FSM, counter and registers.

## Test plan
- x=72, y=9, `en` pulsed → `done` exactly 8 cycles after acceptance, q=8, r=0, `busy` high for 8 cycles.
- x=1000, y=7 → q=142, r=6. x=16'hFEFF, y=8'hFF → q=255, r=254.
- Reset asserted 4 cycles into x=1000, y=7 → outputs are 0 immediately and no `done` pulse follows. A new x=72, y=9 afterwards → q=8, r=0.
- `en` held high, operands changed mid-RUN → first result uses the originally latched operands. `done` pulses recur every 9 cycles.
- With `EIGHT_BIT_DIVIDER_ERR_EN`: y=0 → `done` and `err` at edge N+1, q=r=8'hFF. x=16'h0900, y=9 → `err`=1. x=1000, y=7 → `err`=0.
- Without the macro: `err` stays 0 in every scenario, and valid-operand results match the divisions above.
